// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART host-command sequencer.
//   OP_RD / OP_WR : recognised opcodes (first byte of a frame)
//   TO_RDATA      : read data returned to the host when the bus times out
//   S_*           : sequencer state encodings
//   cmd_frame_t   : frame bytes held between captures
package uart_cmd_pkg;

   localparam logic [7:0]  OP_RD    = 8'h00;
   localparam logic [7:0]  OP_WR    = 8'h01;
   localparam logic [15:0] TO_RDATA = 16'hFFFF;

   localparam int unsigned IDX_W   = 3;
   localparam int unsigned STATE_W = 3;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_CAP    = 3'd2;
   localparam logic [2:0] S_BUS    = 3'd3;
   localparam logic [2:0] S_RESP_H = 3'd4;
   localparam logic [2:0] S_RESP_L = 3'd5;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] addr;
      logic [7:0]  data_h;
   } cmd_frame_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Cycle counter with a programmable limit; used for the bus and frame timeouts.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count this cycle
//   limit      : number of enabled cycles until expiry
//   expired_c  : combinational pulse in the enabled cycle that makes the count reach limit
module cmd_timeout_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expired_c
);

   logic [W-1:0] cnt;

   // Count of enabled cycles seen since the last clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

   // The current cycle is included, so a limit of N expires on the N-th enabled cycle.
   assign expired_c = en && !clr && ((cnt + W'(1)) == limit);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host-command sequencer: pops bytes from the rx FIFO, assembles 3-byte read or
// 5-byte write frames, runs one 16-bit register access per frame and returns read
// data (high byte first) through the tx FIFO.
//   clk, rst            : clock, asynchronous active-high reset
//   rx_rd, rx_emp, rx_re: rx FIFO read data / empty / read strobe
//   tx_wd, tx_we, tx_ful: tx FIFO write data / write strobe / full
//   bus_addr, bus_wdata : register access address and write data
//   bus_we, bus_re      : write / read request, held until bus_ack or timeout
//   bus_rdata, bus_ack  : read data and completion from the register bus
//   busy                : sequencer not idle
//   err_cmd, err_to     : sticky unknown-opcode and timeout flags
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [15:0] BUS_TO   = 16'd1000,
   parameter logic [23:0] FRAME_TO = 24'd240000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_rd,
   input  logic        rx_emp,
   output logic        rx_re,
   output logic [7:0]  tx_wd,
   output logic        tx_we,
   input  logic        tx_ful,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   output logic        bus_we,
   output logic        bus_re,
   input  logic [15:0] bus_rdata,
   input  logic        bus_ack,
   output logic        busy,
   output logic        err_cmd,
   output logic        err_to
);

   logic [STATE_W-1:0] state, state_n;
   logic [IDX_W-1:0]   idx, idx_n;
   cmd_frame_t         frm, frm_n;
   logic [15:0]        rdata, rdata_n, resp_c;
   logic               rx_re_n, tx_we_n, bus_we_n, bus_re_n, err_cmd_n, err_to_n;
   logic [7:0]         tx_wd_n;
   logic [15:0]        bus_addr_n, bus_wdata_n;
   logic               bus_exp_c, frame_exp_c, frame_en_c, frame_clr_c;

   // Bus request timer: runs only while a request is outstanding.
   cmd_timeout_cnt #(.W(16)) u_bus_to (
      .clk       (clk),
      .rst       (rst),
      .clr       (state != S_BUS),
      .en        (state == S_BUS),
      .limit     (BUS_TO),
      .expired_c (bus_exp_c)
   );

   // Inter-byte timer: runs while a partial frame waits on an empty rx FIFO.
   assign frame_en_c  = (idx != '0) && (state == S_IDLE) && rx_emp;
   assign frame_clr_c = (state == S_CAP) || (idx == '0);

   cmd_timeout_cnt #(.W(24)) u_frame_to (
      .clk       (clk),
      .rst       (rst),
      .clr       (frame_clr_c),
      .en        (frame_en_c),
      .limit     (FRAME_TO),
      .expired_c (frame_exp_c)
   );

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         frm       <= '0;
         rdata     <= '0;
         rx_re     <= 1'b0;
         tx_we     <= 1'b0;
         tx_wd     <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_we    <= 1'b0;
         bus_re    <= 1'b0;
         busy      <= 1'b0;
         err_cmd   <= 1'b0;
         err_to    <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         frm       <= frm_n;
         rdata     <= rdata_n;
         rx_re     <= rx_re_n;
         tx_we     <= tx_we_n;
         tx_wd     <= tx_wd_n;
         bus_addr  <= bus_addr_n;
         bus_wdata <= bus_wdata_n;
         bus_we    <= bus_we_n;
         bus_re    <= bus_re_n;
         busy      <= (state_n != S_IDLE);
         err_cmd   <= err_cmd_n;
         err_to    <= err_to_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      frm_n       = frm;
      rdata_n     = rdata;
      rx_re_n     = 1'b0;
      tx_we_n     = 1'b0;
      tx_wd_n     = tx_wd;
      bus_addr_n  = bus_addr;
      bus_wdata_n = bus_wdata;
      bus_we_n    = bus_we;
      bus_re_n    = bus_re;
      err_cmd_n   = err_cmd;
      err_to_n    = err_to;
      resp_c      = bus_ack ? bus_rdata : TO_RDATA;

      case (state)
         S_IDLE: begin
            if (frame_exp_c) begin
               idx_n    = '0;
               err_to_n = 1'b1;
            end else if (!rx_emp) begin
               rx_re_n = 1'b1;
               state_n = S_FETCH;
            end
         end

         S_FETCH: state_n = S_CAP;

         S_CAP: begin
            state_n = S_IDLE;
            idx_n   = idx + IDX_W'(1);
            case (idx)
               3'd0: begin
                  if ((rx_rd != OP_RD) && (rx_rd != OP_WR)) begin
                     err_cmd_n = 1'b1;
                     idx_n     = '0;
                  end else begin
                     frm_n.op = rx_rd;
                  end
               end
               3'd1: frm_n.addr[15:8] = rx_rd;
               3'd2: begin
                  frm_n.addr[7:0] = rx_rd;
                  if (frm.op == OP_RD) begin
                     bus_addr_n = {frm.addr[15:8], rx_rd};
                     bus_re_n   = 1'b1;
                     idx_n      = '0;
                     state_n    = S_BUS;
                  end
               end
               3'd3: frm_n.data_h = rx_rd;
               default: begin
                  bus_addr_n  = frm.addr;
                  bus_wdata_n = {frm.data_h, rx_rd};
                  bus_we_n    = 1'b1;
                  idx_n       = '0;
                  state_n     = S_BUS;
               end
            endcase
         end

         S_BUS: begin
            // Ack wins over a coincident timeout.
            if (bus_ack || bus_exp_c) begin
               bus_we_n = 1'b0;
               bus_re_n = 1'b0;
               if (!bus_ack) err_to_n = 1'b1;
               if (bus_re) begin
                  rdata_n = resp_c;
                  // Issue the high byte straight away when the tx FIFO has room.
                  if (!tx_ful) begin
                     tx_we_n = 1'b1;
                     tx_wd_n = resp_c[15:8];
                     state_n = S_RESP_L;
                  end else begin
                     state_n = S_RESP_H;
                  end
               end else begin
                  state_n = S_IDLE;
               end
            end
         end

         S_RESP_H: begin
            if (!tx_ful) begin
               tx_we_n = 1'b1;
               tx_wd_n = rdata[15:8];
               state_n = S_RESP_L;
            end
         end

         S_RESP_L: begin
            // Skip the cycle of our own write so tx_ful already reflects it.
            if (!tx_ful && !tx_we) begin
               tx_we_n = 1'b1;
               tx_wd_n = rdata[7:0];
               state_n = S_IDLE;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl with rx FIFO, tx FIFO and register-bus models.
module tb_uart_cmd_ctrl;

   localparam logic [15:0] BUS_TO   = 16'd40;
   localparam logic [23:0] FRAME_TO = 24'd200;
   localparam int          TX_CAP   = 1;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } bus_op_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_rd = '0;
   logic        rx_emp = 1'b1;
   logic        rx_re;
   logic [7:0]  tx_wd;
   logic        tx_we;
   logic        tx_ful;
   logic [15:0] bus_addr, bus_wdata;
   logic        bus_we, bus_re;
   logic [15:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic        busy, err_cmd, err_to;

   uart_cmd_ctrl #(.BUS_TO(BUS_TO), .FRAME_TO(FRAME_TO)) dut (
      .clk(clk), .rst(rst), .rx_rd(rx_rd), .rx_emp(rx_emp), .rx_re(rx_re),
      .tx_wd(tx_wd), .tx_we(tx_we), .tx_ful(tx_ful),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .busy(busy), .err_cmd(err_cmd), .err_to(err_to)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // rx FIFO model: data appears the cycle after rx_re.
   logic [7:0] rxq[$];
   logic       push_v = 1'b0;
   logic [7:0] push_b = '0;
   logic       rx_unf = 1'b0;
   always @(posedge clk) begin
      if (rx_re) begin
         if (rxq.size() == 0) rx_unf <= 1'b1;
         else rx_rd <= rxq.pop_front();
      end
      if (push_v) rxq.push_back(push_b);
      rx_emp <= (rxq.size() == 0);
   end

   // tx FIFO model with a random drain; hold_full forces back-pressure.
   int   tx_cnt = 0;
   logic tx_ovf = 1'b0;
   logic hold_full = 1'b0;
   assign tx_ful = hold_full || (tx_cnt >= TX_CAP);
   always @(posedge clk) begin
      int c;
      c = tx_cnt;
      if (c > 0 && $urandom_range(3) == 0) c--;
      if (tx_we) begin
         if (tx_ful) tx_ovf <= 1'b1;
         else c++;
      end
      tx_cnt <= c;
   end

   // Bus model: ack in the ack_delay-th request cycle; ack_delay 0 never acks.
   int          ack_delay = 2;
   int          req_n = 0;
   logic        rd_fixed = 1'b0;
   logic [15:0] rd_val = '0;
   always @(posedge clk) begin
      if (bus_we || bus_re) begin
         req_n <= req_n + 1;
         if (ack_delay > 0 && req_n + 1 == ack_delay - 1) begin
            bus_ack   <= 1'b1;
            bus_rdata <= rd_fixed ? rd_val : 16'($urandom);
         end else begin
            bus_ack <= 1'b0;
         end
      end else begin
         req_n   <= 0;
         bus_ack <= 1'b0;
      end
   end

   bus_op_t    exp_bus[$];
   logic [7:0] exp_tx[$];
   int errors = 0;
   int checks = 0;
   int rise_cyc = 0, last_len = 0, ack_cyc = 0, first_we_cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every bus request and tx byte against the scoreboard queues.
   task automatic monitor();
      logic    req_prev = 1'b0;
      logic    req;
      logic    tx_hi = 1'b1;
      int      len = 0;
      bus_op_t e;
      forever begin
         @(negedge clk);
         if (rx_re) chk("rx_re_while_empty", 64'(rx_emp), 64'd0);
         req = bus_we || bus_re;
         if (req && !req_prev) begin
            rise_cyc = cyc;
            len = 0;
            if (exp_bus.size() == 0) begin
               chk("bus_unexpected_req", 64'(bus_we), 64'(bus_re));
               chk("bus_unexpected_req_any", 64'(req), 64'd0);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_we", 64'(bus_we), 64'(e.we));
               chk("bus_re", 64'(bus_re), 64'(!e.we));
               chk("bus_addr", 64'(bus_addr), 64'(e.addr));
               if (e.we) chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
            end
         end
         if (req) len++;
         if (!req && req_prev) last_len = len;
         req_prev = req;
         if (bus_ack && bus_re) begin
            exp_tx.push_back(bus_rdata[15:8]);
            exp_tx.push_back(bus_rdata[7:0]);
            ack_cyc = cyc;
         end
         if (tx_we) begin
            chk("tx_we_while_full", 64'(tx_ful), 64'd0);
            if (tx_hi) first_we_cyc = cyc;
            tx_hi = !tx_hi;
            if (exp_tx.size() == 0) chk("tx_unexpected_byte", 64'(tx_we), 64'd0);
            else chk("tx_wd", 64'(tx_wd), 64'(exp_tx.pop_front()));
         end
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      push_v = 1'b1;
      push_b = b;
      @(negedge clk);
      push_v = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      exp_bus.push_back({1'b1, a, d});
      push_byte(8'h01); push_byte(a[15:8]); push_byte(a[7:0]);
      push_byte(d[15:8]); push_byte(d[7:0]);
   endtask

   task automatic do_read(input logic [15:0] a, input int dly);
      ack_delay = dly;
      exp_bus.push_back({1'b0, a, 16'h0000});
      if (dly == 0) begin
         exp_tx.push_back(8'hFF);
         exp_tx.push_back(8'hFF);
      end
      push_byte(8'h00); push_byte(a[15:8]); push_byte(a[7:0]);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      repeat (4) @(negedge clk);
      while ((busy || !rx_emp || exp_bus.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
      end
   endtask

   initial begin
      int t0, n, r;
      fork
         monitor();
      join_none

      // Reset state, both during and after reset.
      repeat (3) @(negedge clk);
      chk("rst_ctl", 64'({rx_re, tx_we, tx_wd, bus_we, bus_re, busy, err_cmd, err_to}), 64'd0);
      chk("rst_bus", 64'({bus_addr, bus_wdata}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ctl", 64'({rx_re, tx_we, busy, err_cmd, err_to}), 64'd0);

      // Write frame; last byte delayed to measure its latency to bus_we.
      exp_bus.push_back({1'b1, 16'h000A, 16'h1234});
      push_byte(8'h01); push_byte(8'h00); push_byte(8'h0A); push_byte(8'h12);
      repeat (12) @(negedge clk);
      push_byte(8'h34);
      t0 = cyc;
      wait_idle("t1");
      chk("t1_we_latency", 64'(rise_cyc - t0), 64'd3);

      // Read with ack after 5 cycles.
      rd_fixed = 1'b1; rd_val = 16'hBEEF;
      do_read(16'h000A, 5);
      wait_idle("t2");
      chk("t2_re_hold", 64'(last_len), 64'd5);
      chk("t2_ack_to_tx", 64'(first_we_cyc - ack_cyc), 64'd1);
      rd_fixed = 1'b0;

      // Unknown opcode followed by a normal read.
      push_byte(8'h7F);
      do_read(16'h0001, 3);
      wait_idle("t4");
      chk("t4_err_cmd", 64'(err_cmd), 64'd1);
      chk("t4_err_to", 64'(err_to), 64'd0);

      // tx back-pressure for 100 cycles.
      hold_full = 1'b1;
      do_read(16'h0055, 3);
      repeat (100) @(negedge clk);
      chk("t5_bytes_held", 64'(exp_tx.size()), 64'd2);
      hold_full = 1'b0;
      wait_idle("t5");

      // Partial frame stalled past the frame timeout, then a good read.
      push_byte(8'h01); push_byte(8'h00);
      repeat (int'(FRAME_TO) + 60) @(negedge clk);
      chk("t6_err_to", 64'(err_to), 64'd1);
      chk("t6_busy", 64'(busy), 64'd0);
      do_read(16'h0002, 4);
      wait_idle("t6");

      // Reset while a request is outstanding.
      ack_delay = 0;
      exp_bus.push_back({1'b0, 16'h0077, 16'h0000});
      push_byte(8'h00); push_byte(8'h00); push_byte(8'h77);
      n = 0;
      while (!bus_re && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_bus_reached", 64'(bus_re), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_ctl", 64'({rx_re, tx_we, tx_wd, bus_we, bus_re, busy, err_cmd, err_to}), 64'd0);
      chk("rst_async_bus", 64'({bus_addr, bus_wdata}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_idle("rst");

      // Read that never acks.
      do_read(16'h1234, 0);
      wait_idle("t3");
      chk("t3_re_hold", 64'(last_len), 64'(BUS_TO));
      chk("t3_err_to", 64'(err_to), 64'd1);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(9);
         if (r < 4) do_write(16'($urandom), 16'($urandom));
         else if (r < 8) do_read(16'($urandom), $urandom_range(8, 2));
         else push_byte(8'($urandom_range(255, 2)));
         wait_idle("rand");
      end
      chk("rand_err_cmd", 64'(err_cmd), 64'd1);
      chk("rx_underflow", 64'(rx_unf), 64'd0);
      chk("tx_overflow", 64'(tx_ovf), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
